// File: rtl/icb_acc_ctrl.sv
// ICB slave front end for the MHSA accelerator: CSR block, SRAM write packer, start/done/irq.
// Optional SRAM read-back path is enabled by defining ICB_ACC_SRAM_RDBK_EN.
module icb_acc_ctrl #(
    parameter int unsigned SRAM_WIDTH = 64,
    parameter int unsigned SRAM_DEPTH = 4096,
    parameter int unsigned NUM_BASE   = 2,
    parameter int unsigned REGION_BIT = 16,
    localparam int unsigned LANES     = SRAM_WIDTH / 32,
    localparam int unsigned USRAM_AW  = $clog2(SRAM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    icb_cmd_valid,
    output logic                    icb_cmd_ready,
    input  logic                    icb_cmd_read,
    input  logic [31:0]             icb_cmd_addr,
    input  logic [31:0]             icb_cmd_wdata,
    input  logic [3:0]              icb_cmd_wmask,
    output logic                    icb_rsp_valid,
    input  logic                    icb_rsp_ready,
    output logic [31:0]             icb_rsp_rdata,
    output logic                    icb_rsp_err,
    output logic                    acc_start,
    input  logic                    acc_done,
    output logic [NUM_BASE*32-1:0]  acc_base,
    output logic                    usram_write_en,
    output logic [USRAM_AW-1:0]     usram_addr,
    output logic [SRAM_WIDTH-1:0]   usram_wdata,
`ifdef ICB_ACC_SRAM_RDBK_EN
    output logic                    usram_read_en,
    input  logic [SRAM_WIDTH-1:0]   usram_rdata,
`endif
    output logic                    irq
);

    localparam int unsigned LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned BYTE_SH   = $clog2(SRAM_WIDTH / 8);

    typedef enum logic [1:0] {StIdle, StRsp, StRdWait} state_e;

    state_e                       state_q, state_d;
    logic [31:0]                  rsp_rdata_q, rsp_rdata_d;
    logic                         rsp_err_q, rsp_err_d;
    logic                         irq_en_q, irq_en_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic [NUM_BASE-1:0][31:0]    base_q, base_d;
    logic [LANES-1:0][31:0]       buf_q, buf_d, buf_merged;
    logic [LANE_BITS-1:0]         pack_cnt_q, pack_cnt_d;
    logic                         acc_start_q, acc_start_d;
    logic                         usram_we_q, usram_we_d;
    logic [USRAM_AW-1:0]          usram_addr_q, usram_addr_d;
    logic [SRAM_WIDTH-1:0]        usram_wdata_q, usram_wdata_d;

    logic [7:0]                   csr_off;
    logic [31:0]                  sram_off, sram_word, sram_lane, rd_val;
    logic [LANE_BITS-1:0]         lane_sel;
    logic                         word_ok, err_rsp;
    logic                         unused_bits;

`ifdef ICB_ACC_SRAM_RDBK_EN
    logic                         usram_re_q, usram_re_d;
    logic [LANE_BITS-1:0]         rd_lane_q, rd_lane_d;
    logic [LANES-1:0][31:0]       rd_lanes;
    assign rd_lanes      = usram_rdata;
    assign usram_read_en = usram_re_q;
`endif

    assign csr_off   = icb_cmd_addr[7:0];
    assign sram_off  = icb_cmd_addr & ((32'd1 << REGION_BIT) - 32'd1);
    assign sram_word = sram_off >> BYTE_SH;
    assign sram_lane = (sram_off >> 2) & 32'(LANES - 1);
    assign lane_sel  = sram_lane[LANE_BITS-1:0];
    assign word_ok   = sram_word < 32'(SRAM_DEPTH);
    assign unused_bits = ^{icb_cmd_addr, sram_off, sram_word, sram_lane};

    always_comb begin
        state_d       = state_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        irq_en_d      = irq_en_q;
        busy_d        = busy_q;
        done_d        = done_q;
        err_d         = err_q;
        base_d        = base_q;
        buf_d         = buf_q;
        pack_cnt_d    = pack_cnt_q;
        acc_start_d   = 1'b0;
        usram_we_d    = 1'b0;
        usram_addr_d  = usram_addr_q;
        usram_wdata_d = usram_wdata_q;
        rd_val        = 32'd0;
        err_rsp       = 1'b0;
        buf_merged    = buf_q;
        buf_merged[lane_sel] = icb_cmd_wdata;
`ifdef ICB_ACC_SRAM_RDBK_EN
        usram_re_d    = 1'b0;
        rd_lane_d     = rd_lane_q;
`endif

        case (state_q)
            StIdle: begin
                if (icb_cmd_valid) begin
                    state_d = StRsp;
                    if (!icb_cmd_addr[REGION_BIT]) begin
                        if (csr_off == 8'h00) begin
                            if (icb_cmd_read) begin
                                rd_val = {30'd0, irq_en_q, 1'b0};
                            end else if (icb_cmd_wdata[0] && busy_q) begin
                                err_rsp = 1'b1;
                                err_d   = 1'b1;
                            end else begin
                                irq_en_d = icb_cmd_wdata[1];
                                if (icb_cmd_wdata[0]) begin
                                    acc_start_d = 1'b1;
                                    busy_d      = 1'b1;
                                    buf_d       = '0;
                                    pack_cnt_d  = '0;
                                end
                            end
                        end else if (csr_off == 8'h04) begin
                            if (icb_cmd_read) begin
                                rd_val = {29'd0, err_q, done_q, busy_q};
                            end else begin
                                if (icb_cmd_wdata[1]) done_d = 1'b0;
                                if (icb_cmd_wdata[2]) err_d = 1'b0;
                            end
                        end else if (csr_off == 8'h08) begin
                            if (icb_cmd_read) rd_val = 32'(pack_cnt_q);
                        end else begin
                            err_rsp = 1'b1;
                            for (int unsigned i = 0; i < NUM_BASE; i++) begin
                                if (csr_off == 8'(16 + 4 * i)) begin
                                    err_rsp = 1'b0;
                                    if (icb_cmd_read) begin
                                        rd_val = base_q[i];
                                    end else begin
                                        for (int unsigned b = 0; b < 4; b++) begin
                                            if (icb_cmd_wmask[b]) begin
                                                base_d[i][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                                            end
                                        end
                                    end
                                end
                            end
                        end
                    end else if (icb_cmd_read) begin
`ifdef ICB_ACC_SRAM_RDBK_EN
                        if (!busy_q && word_ok) begin
                            usram_re_d   = 1'b1;
                            usram_addr_d = sram_word[USRAM_AW-1:0];
                            rd_lane_d    = lane_sel;
                            state_d      = StRdWait;
                        end else begin
                            err_rsp = 1'b1;
                        end
`else
                        err_rsp = 1'b1;
`endif
                    end else if (!busy_q && icb_cmd_wmask == 4'hF && word_ok &&
                                 sram_lane == 32'(pack_cnt_q)) begin
                        buf_d = buf_merged;
                        if (sram_lane == 32'(LANES - 1)) begin
                            usram_we_d    = 1'b1;
                            usram_addr_d  = sram_word[USRAM_AW-1:0];
                            usram_wdata_d = buf_merged;
                            buf_d         = '0;
                            pack_cnt_d    = '0;
                        end else begin
                            pack_cnt_d = pack_cnt_q + 1'b1;
                        end
                    end else begin
                        // Out-of-order or partial writes abandon the partially packed word.
                        err_rsp    = 1'b1;
                        err_d      = 1'b1;
                        buf_d      = '0;
                        pack_cnt_d = '0;
                    end
                    rsp_err_d   = err_rsp;
                    rsp_rdata_d = err_rsp ? 32'd0 : rd_val;
                end
            end
            StRsp: begin
                if (icb_rsp_ready) state_d = StIdle;
            end
`ifdef ICB_ACC_SRAM_RDBK_EN
            StRdWait: begin
                // SRAM data is sampled at the end of the read-enable cycle.
                rsp_rdata_d = rd_lanes[rd_lane_q];
                rsp_err_d   = 1'b0;
                state_d     = StRsp;
            end
`endif
            default: state_d = StIdle;
        endcase

        // Applied last so a done pulse beats a simultaneous W1C of done.
        if (acc_done && busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            irq_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            base_q        <= '0;
            buf_q         <= '0;
            pack_cnt_q    <= '0;
            acc_start_q   <= 1'b0;
            usram_we_q    <= 1'b0;
            usram_addr_q  <= '0;
            usram_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            irq_en_q      <= irq_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            base_q        <= base_d;
            buf_q         <= buf_d;
            pack_cnt_q    <= pack_cnt_d;
            acc_start_q   <= acc_start_d;
            usram_we_q    <= usram_we_d;
            usram_addr_q  <= usram_addr_d;
            usram_wdata_q <= usram_wdata_d;
        end
    end

`ifdef ICB_ACC_SRAM_RDBK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usram_re_q <= 1'b0;
            rd_lane_q  <= '0;
        end else begin
            usram_re_q <= usram_re_d;
            rd_lane_q  <= rd_lane_d;
        end
    end
`endif

    assign icb_cmd_ready  = (state_q == StIdle);
    assign icb_rsp_valid  = (state_q == StRsp);
    assign icb_rsp_rdata  = rsp_rdata_q;
    assign icb_rsp_err    = rsp_err_q;
    assign acc_start      = acc_start_q;
    assign acc_base       = base_q;
    assign usram_write_en = usram_we_q;
    assign usram_addr     = usram_addr_q;
    assign usram_wdata    = usram_wdata_q;
    assign irq            = done_q & irq_en_q;

endmodule

// File: tb/tb_icb_acc_ctrl.sv
// Randomized bench for icb_acc_ctrl (default parameters) against a transaction-level model.
module tb_icb_acc_ctrl;

    localparam int unsigned NUM_BASE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icb_cmd_valid = 1'b0;
    logic        icb_cmd_ready;
    logic        icb_cmd_read = 1'b0;
    logic [31:0] icb_cmd_addr = '0;
    logic [31:0] icb_cmd_wdata = '0;
    logic [3:0]  icb_cmd_wmask = '0;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready = 1'b0;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        acc_start;
    logic        acc_done = 1'b0;
    logic [63:0] acc_base;
    logic        usram_write_en;
    logic [11:0] usram_addr;
    logic [63:0] usram_wdata;
    logic        irq;

    icb_acc_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icb_cmd_valid  (icb_cmd_valid),
        .icb_cmd_ready  (icb_cmd_ready),
        .icb_cmd_read   (icb_cmd_read),
        .icb_cmd_addr   (icb_cmd_addr),
        .icb_cmd_wdata  (icb_cmd_wdata),
        .icb_cmd_wmask  (icb_cmd_wmask),
        .icb_rsp_valid  (icb_rsp_valid),
        .icb_rsp_ready  (icb_rsp_ready),
        .icb_rsp_rdata  (icb_rsp_rdata),
        .icb_rsp_err    (icb_rsp_err),
        .acc_start      (acc_start),
        .acc_done       (acc_done),
        .acc_base       (acc_base),
        .usram_write_en (usram_write_en),
        .usram_addr     (usram_addr),
        .usram_wdata    (usram_wdata),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_busy, m_done, m_err, m_irq_en;
    logic [31:0] m_base [NUM_BASE];
    logic [31:0] pend [$];
    int          m_starts = 0, m_writes = 0;
    int          seen_starts = 0, seen_writes = 0;

    always @(posedge clk) begin
        if (acc_start === 1'b1) seen_starts <= seen_starts + 1;
        if (usram_write_en === 1'b1) seen_writes <= seen_writes + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_irq_en = 0;
        for (int i = 0; i < NUM_BASE; i++) m_base[i] = '0;
        pend.delete();
    endtask

    task automatic txn(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm, input int stall, input bit done_same,
                       output logic [31:0] obs);
        bit          e_err, e_start, e_we, done_hit;
        logic [31:0] e_rd;
        logic [63:0] e_wdata;
        int          off, lane, word, wait_cyc;
        e_err = 0; e_start = 0; e_we = 0; e_rd = '0; e_wdata = '0; word = 0;
        done_hit = done_same && m_busy;
        if (!addr[16]) begin
            off = int'(addr[7:0]);
            if (off == 0) begin
                if (rd) e_rd = {30'd0, m_irq_en, 1'b0};
                else if (wd[0] && m_busy) begin e_err = 1; m_err = 1; end
                else begin
                    m_irq_en = wd[1];
                    if (wd[0]) begin e_start = 1; m_busy = 1; pend.delete(); end
                end
            end else if (off == 4) begin
                if (rd) e_rd = {29'd0, m_err, m_done, m_busy};
                else begin
                    if (wd[1]) m_done = 0;
                    if (wd[2]) m_err = 0;
                end
            end else if (off == 8) begin
                if (rd) e_rd = pend.size();
            end else if (off >= 16 && off < 16 + 4 * NUM_BASE && off % 4 == 0) begin
                if (rd) e_rd = m_base[(off - 16) / 4];
                else for (int b = 0; b < 4; b++)
                    if (wm[b]) m_base[(off - 16) / 4][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e_err = 1;
            end
        end else begin
            lane = int'(addr[2]);
            word = int'(addr[15:0]) / 8;
            if (rd) e_err = 1;
            else if (!m_busy && wm == 4'hF && lane == pend.size() && word < 4096) begin
                pend.push_back(wd);
                if (pend.size() == 2) begin
                    e_we = 1;
                    e_wdata = {pend[1], pend[0]};
                    pend.delete();
                end
            end else begin
                e_err = 1; m_err = 1; pend.delete();
            end
        end
        if (done_hit) begin m_busy = 0; m_done = 1; end
        if (e_start) m_starts++;
        if (e_we) m_writes++;

        @(negedge clk);
        icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
        icb_cmd_wdata = wd; icb_cmd_wmask = wm; acc_done = done_same;
        wait_cyc = 0;
        while (icb_cmd_ready !== 1'b1 && wait_cyc < 8) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("cmd_ready_idle", icb_cmd_ready, 1'b1);
        if (icb_cmd_ready !== 1'b1) $fatal(1, "stuck waiting for command ready");
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0; acc_done = 1'b0;
        @(negedge clk);
        check("rsp_valid", icb_rsp_valid, 1'b1);
        check("rsp_err", icb_rsp_err, e_err);
        check("rsp_rdata", icb_rsp_rdata, e_rd);
        check("acc_start", acc_start, e_start);
        check("usram_we", usram_write_en, e_we);
        check("cmd_ready_busy", icb_cmd_ready, 1'b0);
        if (e_we) begin
            check("usram_addr", usram_addr, 64'(word));
            check("usram_wdata", usram_wdata, e_wdata);
        end
        obs = icb_rsp_rdata;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", icb_rsp_valid, 1'b1);
            check("stall_rdata", icb_rsp_rdata, e_rd);
            check("stall_err", icb_rsp_err, e_err);
            check("stall_cmd_ready", icb_cmd_ready, 1'b0);
            check("stall_pulses", {acc_start, usram_write_en}, 2'b00);
        end
        icb_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        icb_rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_released", icb_rsp_valid, 1'b0);
        check("irq", irq, m_done && m_irq_en);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        acc_done = 1'b1;
        @(posedge clk);
        #1;
        acc_done = 1'b0;
        if (m_busy) begin m_busy = 0; m_done = 1; end
        @(negedge clk);
        check("irq_after_done", irq, m_done && m_irq_en);
    endtask

    logic [31:0] obs, addr, wd;
    logic [3:0]  wm;
    int          kind, lane, word;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_outputs", {icb_rsp_valid, icb_rsp_err, acc_start, usram_write_en, irq}, '0);
        check("rst_rdata", icb_rsp_rdata, '0);
        check("rst_acc_base", acc_base, '0);
        check("rst_usram", {usram_addr, usram_wdata[51:0]}, '0);
        rst_n = 1'b1;

        txn(1, 32'h0000_0004, '0, 4'h0, 0, 0, obs);
        check("status_after_rst", obs, 32'h0);

        txn(0, 32'h0000_0014, 32'h0, 4'hF, 0, 0, obs);
        txn(0, 32'h0000_0014, 32'hDEAD_BEEF, 4'b0011, 0, 0, obs);
        txn(1, 32'h0000_0014, '0, 4'h0, 0, 0, obs);
        check("base1_bytewise", obs, 32'h0000_BEEF);
        check("acc_base1", acc_base[63:32], 32'h0000_BEEF);

        txn(0, 32'h0001_0010, 32'h1111_1111, 4'hF, 0, 0, obs);
        txn(0, 32'h0001_0014, 32'h2222_2222, 4'hF, 0, 0, obs);
        check("strobe_count_pack", seen_writes, 1);
        txn(1, 32'h0000_0008, '0, 4'h0, 0, 0, obs);
        check("pack_after_word", obs, 32'h0);

        txn(0, 32'h0001_0004, 32'h3333_3333, 4'hF, 0, 0, obs);
        txn(1, 32'h0000_0004, '0, 4'h0, 0, 0, obs);
        check("status_err_set", obs[2], 1'b1);
        txn(0, 32'h0000_0004, 32'h4, 4'hF, 0, 0, obs);
        txn(1, 32'h0000_0004, '0, 4'h0, 0, 0, obs);
        check("status_err_cleared", obs[2], 1'b0);

        txn(0, 32'h0000_0000, 32'h3, 4'hF, 0, 0, obs);
        txn(1, 32'h0000_0004, '0, 4'h0, 0, 0, obs);
        check("busy_after_start", obs[0], 1'b1);
        txn(0, 32'h0000_0000, 32'h3, 4'hF, 0, 0, obs);
        pulse_done();
        check("irq_raised", irq, 1'b1);
        txn(0, 32'h0000_0004, 32'h2, 4'hF, 0, 0, obs);
        check("irq_cleared", irq, 1'b0);

        // Done arriving with a W1C of done must leave done set.
        txn(0, 32'h0000_0000, 32'h1, 4'hF, 0, 0, obs);
        txn(0, 32'h0000_0004, 32'h2, 4'hF, 0, 1, obs);
        txn(1, 32'h0000_0004, '0, 4'h0, 0, 0, obs);
        check("done_set_wins", obs[1:0], 2'b10);
        txn(0, 32'h0000_0004, 32'h6, 4'hF, 0, 0, obs);

        txn(0, 32'h0000_0010, 32'h0000_1234, 4'hF, 0, 0, obs);
        txn(1, 32'h0000_0010, '0, 4'h0, 5, 0, obs);
        check("stall_base0", obs, 32'h0000_1234);

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            addr = $urandom & 32'hFFFE_FF00;
            wd = $urandom;
            wm = 4'hF;
            case (kind)
                0: begin
                    case ($urandom_range(0, 7))
                        0: addr[7:0] = 8'h00;
                        1: addr[7:0] = 8'h04;
                        2: addr[7:0] = 8'h08;
                        3: addr[7:0] = 8'h0C;
                        4: addr[7:0] = 8'h10;
                        5: addr[7:0] = 8'h14;
                        6: addr[7:0] = 8'h18;
                        default: addr[7:0] = 8'($urandom);
                    endcase
                    txn(1, addr, '0, 4'h0, $urandom_range(0, 3), $urandom_range(0, 7) == 0, obs);
                end
                1: txn(0, addr, 32'($urandom_range(0, 3)), wm, $urandom_range(0, 2),
                       $urandom_range(0, 3) == 0, obs);
                2: txn(0, addr | 32'h4, 32'($urandom_range(0, 7)), wm, 0,
                       $urandom_range(0, 3) == 0, obs);
                3: txn(0, addr | (32'h10 + 32'($urandom_range(0, 1)) * 4), wd, 4'($urandom),
                       $urandom_range(0, 2), 0, obs);
                4, 5, 6, 7: begin
                    lane = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : pend.size();
                    word = ($urandom_range(0, 9) == 0) ? $urandom_range(4096, 8191)
                                                       : $urandom_range(0, 4095);
                    if ($urandom_range(0, 7) == 0) wm = 4'($urandom);
                    addr = ($urandom & 32'hFFFE_0000) | 32'h0001_0000 |
                           (32'(word) << 3) | (32'(lane) << 2);
                    txn(0, addr, wd, wm, $urandom_range(0, 2), 0, obs);
                end
                8: txn(1, 32'h0001_0000 | ($urandom & 32'hFFFF), '0, 4'h0, 0, 0, obs);
                default: pulse_done();
            endcase
        end

        // Reset while a response is pending drops it.
        @(negedge clk);
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h4;
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_rsp", icb_rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_rsp", icb_rsp_valid, 1'b0);
        check("reset_cmd_ready", icb_cmd_ready, 1'b1);
        check("reset_acc_base", acc_base, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        txn(1, 32'h0000_0004, '0, 4'h0, 0, 0, obs);
        check("status_post_reset", obs, 32'h0);

        check("total_starts", seen_starts, m_starts);
        check("total_writes", seen_writes, m_writes);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
